// File: rtl/bombe_rotor_stepper_pkg.sv
// bombe_rotor_stepper_pkg: shared constants, FSM encoding and position helpers
package bombe_rotor_stepper_pkg;
  localparam int NUM_POS = 26;
  localparam int POS_W = 5;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_POS - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, ADVANCE = 2'd1, ACK = 2'd2} state_t;
  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
    return (p == POS_MAX) ? '0 : p + POS_W'(1);
  endfunction
  // out-of-range start values collapse to position 0
  function automatic logic [POS_W-1:0] pos_clamp(input logic [POS_W-1:0] p);
    return (p > POS_MAX) ? '0 : p;
  endfunction
endpackage

// File: rtl/bombe_rotor_stepper_rotor_position_counter.sv
// rotor_position_counter: one mod-26 rotor position with a carry-out wrap
module rotor_position_counter
  import bombe_rotor_stepper_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [POS_W-1:0] init,
  input  logic             en,
  output logic [POS_W-1:0] pos,
  output logic             wrap
);
  logic [POS_W-1:0] pos_d, pos_q;
  always_comb pos_d = load ? pos_clamp(init) : en ? pos_inc(pos_q) : pos_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) pos_q <= '0;
    else pos_q <= pos_d;
  assign pos = pos_q;
  assign wrap = en && (pos_q == POS_MAX);
endmodule

// File: rtl/bombe_rotor_stepper.sv
// bombe_rotor_stepper: req/ack-driven three-rotor odometer with return-to-start detection
module bombe_rotor_stepper
  import bombe_rotor_stepper_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [POS_W-1:0] init_fast,
  input  logic [POS_W-1:0] init_mid,
  input  logic [POS_W-1:0] init_slow,
  input  logic             step_req,
  output logic             step_ack,
  output logic [POS_W-1:0] pos_fast,
  output logic [POS_W-1:0] pos_mid,
  output logic [POS_W-1:0] pos_slow,
  output logic             cycle_done,
  output logic             busy
);
  state_t state_d, state_q;
  logic step_ack_d, step_ack_q, cycle_done_d, cycle_done_q;
  logic [POS_W-1:0] start_fast_d, start_fast_q, start_mid_d, start_mid_q, start_slow_d, start_slow_q;
  logic adv, wrap_fast, wrap_mid, wrap_slow, en_mid, en_slow;
  logic [POS_W-1:0] nxt_fast, nxt_mid, nxt_slow;
  assign adv = (state_q == ADVANCE);
  assign en_mid = adv && wrap_fast;
  assign en_slow = en_mid && wrap_mid;
  rotor_position_counter u_fast (
    .clk(clk), .reset(reset), .load(load), .init(init_fast), .en(adv),
    .pos(pos_fast), .wrap(wrap_fast)
  );
  rotor_position_counter u_mid (
    .clk(clk), .reset(reset), .load(load), .init(init_mid), .en(en_mid),
    .pos(pos_mid), .wrap(wrap_mid)
  );
  rotor_position_counter u_slow (
    .clk(clk), .reset(reset), .load(load), .init(init_slow), .en(en_slow),
    .pos(pos_slow), .wrap(wrap_slow)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = step_req ? ADVANCE : IDLE;
      ADVANCE: state_d = ACK;
      ACK:     state_d = step_req ? ACK : IDLE;
      default: state_d = IDLE;
    endcase
    if (load) state_d = IDLE;
    step_ack_d = (state_d == ACK);
    // post-advance positions, compared against the start registers
    nxt_fast = pos_inc(pos_fast);
    nxt_mid = en_mid ? pos_inc(pos_mid) : pos_mid;
    nxt_slow = en_slow ? pos_inc(pos_slow) : pos_slow;
    cycle_done_d = load ? 1'b0
                 : (adv && nxt_fast == start_fast_q && nxt_mid == start_mid_q && nxt_slow == start_slow_q) ? 1'b1
                 : cycle_done_q;
    start_fast_d = load ? pos_clamp(init_fast) : start_fast_q;
    start_mid_d = load ? pos_clamp(init_mid) : start_mid_q;
    start_slow_d = load ? pos_clamp(init_slow) : start_slow_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      step_ack_q <= 1'b0;
      cycle_done_q <= 1'b0;
      start_fast_q <= '0;
      start_mid_q <= '0;
      start_slow_q <= '0;
    end else begin
      state_q <= state_d;
      step_ack_q <= step_ack_d;
      cycle_done_q <= cycle_done_d;
      start_fast_q <= start_fast_d;
      start_mid_q <= start_mid_d;
      start_slow_q <= start_slow_d;
    end
  assign step_ack = step_ack_q;
  assign cycle_done = cycle_done_q;
  assign busy = (state_q != IDLE);
  logic unused_wrap;
  assign unused_wrap = wrap_slow;
endmodule

// File: tb/tb_bombe_rotor_stepper.sv
// tb_bombe_rotor_stepper: directed handshake, carry, load, wrap-around and reset checks
module tb_bombe_rotor_stepper;
  logic clk = 0, reset = 1, load = 0, step_req = 0;
  logic [4:0] init_fast = 0, init_mid = 0, init_slow = 0;
  logic step_ack, cycle_done, busy;
  logic [4:0] pos_fast, pos_mid, pos_slow;
  int n_cmp = 0, n_err = 0;
  bombe_rotor_stepper dut (
    .clk(clk), .reset(reset), .load(load), .init_fast(init_fast), .init_mid(init_mid),
    .init_slow(init_slow), .step_req(step_req), .step_ack(step_ack), .pos_fast(pos_fast),
    .pos_mid(pos_mid), .pos_slow(pos_slow), .cycle_done(cycle_done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_pos(input string tag, input int f, input int m, input int s);
    chk({tag, ".fast"}, 32'(pos_fast), 32'(f));
    chk({tag, ".mid"}, 32'(pos_mid), 32'(m));
    chk({tag, ".slow"}, 32'(pos_slow), 32'(s));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input int f, input int m, input int s);
    init_fast = 5'(f);
    init_mid = 5'(m);
    init_slow = 5'(s);
    load = 1;
    tick();
    load = 0;
  endtask
  task automatic step();
    step_req = 1;
    tick();
    tick();
    step_req = 0;
    tick();
  endtask
  initial begin
    #12;
    chk("rst_ack", 32'(step_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(cycle_done), 0);
    chk_pos("rst_pos", 0, 0, 0);
    reset = 0;
    tick();
    step_req = 1;
    tick();
    chk("hs_busy_adv", 32'(busy), 1);
    chk("hs_ack_adv", 32'(step_ack), 0);
    chk_pos("hs_pos_adv", 0, 0, 0);
    tick();
    chk("hs_ack_2cyc", 32'(step_ack), 1);
    chk_pos("hs_pos_ack", 1, 0, 0);
    step_req = 0;
    tick();
    chk("hs_ack_drop", 32'(step_ack), 0);
    chk("hs_busy_drop", 32'(busy), 0);
    do_load(25, 25, 24);
    chk_pos("load_252524", 25, 25, 24);
    step();
    chk_pos("carry_slow", 0, 0, 25);
    step();
    chk_pos("carry_next", 1, 0, 25);
    do_load(25, 25, 25);
    step();
    chk_pos("full_wrap", 0, 0, 0);
    step_req = 1;
    for (int i = 0; i < 10; i++) tick();
    chk_pos("hold_one_adv", 1, 0, 0);
    chk("hold_ack", 32'(step_ack), 1);
    chk("hold_busy", 32'(busy), 1);
    step_req = 0;
    tick();
    chk("hold_ack_drop", 32'(step_ack), 0);
    do_load(3, 7, 12);
    for (int i = 0; i < 17575; i++) step();
    chk("done_before", 32'(cycle_done), 0);
    chk_pos("pos_before", 2, 7, 12);
    step_req = 1;
    tick();
    chk("done_pre_edge", 32'(cycle_done), 0);
    tick();
    chk("done_set", 32'(cycle_done), 1);
    chk_pos("done_pos", 3, 7, 12);
    step_req = 0;
    tick();
    step();
    chk_pos("after_done", 4, 7, 12);
    chk("done_sticky", 32'(cycle_done), 1);
    do_load(3, 7, 12);
    chk("done_cleared", 32'(cycle_done), 0);
    step_req = 1;
    tick();
    chk("adv_state", 32'(busy), 1);
    init_fast = 5'd30;
    init_mid = 5'd2;
    init_slow = 5'd5;
    load = 1;
    step_req = 0;
    tick();
    load = 0;
    chk_pos("load_in_adv", 0, 2, 5);
    chk("load_adv_ack", 32'(step_ack), 0);
    chk("load_adv_idle", 32'(busy), 0);
    tick();
    chk_pos("load_adv_noadv", 0, 2, 5);
    step_req = 1;
    tick();
    tick();
    chk("pre_rst_ack", 32'(step_ack), 1);
    chk_pos("pre_rst_pos", 1, 2, 5);
    #2 reset = 1;
    #1;
    chk("arst_ack", 32'(step_ack), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(cycle_done), 0);
    chk_pos("arst_pos", 0, 0, 0);
    step_req = 0;
    tick();
    reset = 0;
    tick();
    step();
    chk_pos("post_rst_step", 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bombe_rotor_stepper.md
Name: bombe_rotor_stepper

Overview:
- Receiver end of the rotor key-press protocol. Where a single clocked rotor is driven by press/release strobes, this block accepts step requests over a four-phase req/ack handshake.
- Each accepted request advances a three-rotor odometer (fast, middle, slow), each rotor covering positions 0..25, with carry from one rotor to the next.
- It signals when the stack has cycled back to its loaded start position.
- It sits between the bombe search controller (which issues step requests) and the rotor datapaths (which consume the positions).

Parameters:
- NUM_POS, 26, number of positions per rotor; positions run 0..NUM_POS-1.
- POS_W, 5, width of each position field.

Ports:
- clk  input  1  clock, positive edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  synchronous load of the start positions; highest priority after reset.
- init_fast  input  POS_W  start position of the fast rotor.
- init_mid  input  POS_W  start position of the middle rotor.
- init_slow  input  POS_W  start position of the slow rotor.
- step_req  input  1  step request, four-phase handshake.
- step_ack  output  1  step acknowledge.
- pos_fast  output  POS_W  current position of the fast rotor.
- pos_mid  output  POS_W  current position of the middle rotor.
- pos_slow  output  POS_W  current position of the slow rotor.
- cycle_done  output  1  sticky flag: the stack has returned to its start positions.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, active-high) sets:
  - all positions to 0 and stored start registers to 0,0,0;
  - step_ack=0, cycle_done=0, busy=0;
  - FSM to IDLE.
- FSM states: IDLE, ADVANCE, ACK.
  - IDLE: if step_req=1, go to ADVANCE.
  - ADVANCE: lasts exactly 1 cycle. Positions update on the exiting edge; go to ACK.
  - ACK: step_ack=1. Hold until step_req=0, then go to IDLE with step_ack=0 on the next edge.
- Handshake rules:
  - Latency is 2 cycles from step_req sampled high to step_ack high.
  - One advance per handshake. A req held high through ACK must not cause a second step.
  - step_ack is registered and deasserts 1 cycle after step_req is sampled low.
- Advance arithmetic:
  - fast = fast+1 mod 26.
  - When fast wraps 25->0, mid = mid+1 mod 26.
  - When mid and fast both wrap in the same advance, slow = slow+1 mod 26.
  - 25,25,25 steps to 0,0,0.
- Load:
  - Synchronous and honoured in any state. Positions and stored start registers take the init values.
  - Clears cycle_done and step_ack; FSM goes to IDLE.
  - load overrides a coincident step_req. A request still held high after load drops starts a fresh handshake.
  - Init values 26..31 load as 0 into both position and start registers.
- cycle_done:
  - Set on the ADVANCE edge when the post-advance positions equal the stored start registers, i.e. after 17576 advances.
  - Stays set; cleared only by load or reset.
  - Stepping continues normally while it is set.
- Reset mid-handshake: outputs go to their reset values immediately. The requester must drop and re-raise step_req to start a new handshake.
- busy = (state != IDLE), decoded from registered state.

Decomposition:
- Shared package: NUM_POS, POS_W, the state encodings (IDLE, ADVANCE, ACK), and a position-max constant (25).
- Sub-module: rotor_position_counter. One instance per rotor, 3 instances total.
  - Inputs: clk, reset, load, init, en.
  - Outputs: pos, wrap. wrap is combinational: en && pos==25.
  - Carry chain: en_mid = adv && wrap_fast; en_slow = en_mid && wrap_mid.

Test Plan:
- Reset, then one handshake: positions go 0,0,0 -> 1,0,0 (fast,mid,slow); step_ack high 2 cycles after req, low 1 cycle after req drops; busy high during the handshake.
- Load 25,25,24, then step: positions 0,0,25. Step again: 1,0,25. Load 25,25,25, then step: 0,0,0.
- Hold step_req high for 10 cycles: exactly one advance; step_ack stays high until req drops.
- Load 3,7,12, then run 17576 handshakes: cycle_done rises exactly on the final ADVANCE edge with positions 3,7,12. One more step gives 4,7,12 with cycle_done still 1. Then load clears it.
- Assert load in the ADVANCE state with init 30,2,5: positions become 0,2,5, no advance occurs, step_ack=0, FSM in IDLE.
- Assert reset asynchronously during ACK: step_ack drops before the next clock edge, all positions read 0, cycle_done=0.
